// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity and frame-length helpers.
// Used by both the transmitter and the receiver.
package uart_pkg;

  // Widest data word either end of the link supports.
  localparam int unsigned MAX_DATA_BW = 9;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Parity over a zero-extended word; the extra zero bits do not change the XOR.
  function automatic logic calc_parity(input logic [MAX_DATA_BW-1:0] data,
                                       input logic                   odd);
    return (^data) ^ odd;
  endfunction

  // Clock cycles from the first start-bit cycle to the end of the last stop bit.
  function automatic int unsigned frame_len(input int unsigned clk_div,
                                            input int unsigned data_bw,
                                            input int unsigned parity_en,
                                            input int unsigned stop_bits);
    return (1 + data_bw + parity_en + stop_bits) * clk_div;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Producer-to-transmitter word handshake (valid/ready).
interface uart_tx_if #(
  parameter int unsigned DATA_BW = 8
) ();

  logic [DATA_BW-1:0] data_i;
  logic               valid_i;
  logic               ready_o;

  modport master (output data_i, output valid_i, input  ready_o);
  modport slave  (input  data_i, input  valid_i, output ready_o);

endinterface

// File: rtl/uart_tx_counter.sv
// Free-running up-counter with asynchronous reset and synchronous clear.
module uart_tx_counter #(
  parameter int unsigned BW = 4
) (
  input  logic          clk_i,
  input  logic          nrst_i,
  input  logic          nrstSync_i,
  output logic [BW-1:0] cnt_o
);

  // Count every cycle; a synchronous clear restarts from zero.
  // NOTE: non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      cnt_o <= '0;
    end else if (!nrstSync_i) begin
      cnt_o <= '0;
    end else begin
      cnt_o <= cnt_o + BW'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts a word over valid/ready and shifts it out LSB-first
// as start bit, data bits, optional parity bit and 1 or 2 stop bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned DATA_BW    = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic  clk_i,
  input  logic  nrst_i,
  input  logic  nrstSync_i,
  uart_tx_if.slave bus,
  output logic  tx_o,
  output logic  busy_o
);

  localparam int unsigned TW  = $clog2(CLK_DIV);
  localparam int unsigned BCW = $clog2(DATA_BW + 1);

  localparam logic [TW-1:0]  TICK_AT   = TW'(CLK_DIV - 1);
  localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_BW - 1);
  localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);

  uart_state_e        state_q, state_d;
  logic [DATA_BW-1:0] shift_q, shift_d;
  logic [BCW-1:0]     bit_cnt_q, bit_cnt_d;
  logic               tx_q, tx_d;
  logic               parity_q, parity_d;

  logic [TW-1:0]      timer;
  logic               tick;
  logic               accept;
  logic               timer_clr_n;

  assign accept      = bus.valid_i && (state_q == ST_IDLE);
  assign tick        = (timer == TICK_AT);
  // Restart the bit period at every bit boundary, at acceptance and on clear.
  assign timer_clr_n = nrstSync_i && !tick && !accept;

  uart_tx_counter #(
    .BW (TW)
  ) bit_timer (
    .clk_i      (clk_i),
    .nrst_i     (nrst_i),
    .nrstSync_i (timer_clr_n),
    .cnt_o      (timer)
  );

  // Next-state and next-output decode; the clear overrides everything.
  // NOTE: every target gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    parity_d  = parity_q;

    if (!nrstSync_i) begin
      state_d   = ST_IDLE;
      shift_d   = '0;
      bit_cnt_d = '0;
      tx_d      = 1'b1;
      parity_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.valid_i) begin
            state_d   = ST_START;
            shift_d   = bus.data_i;
            parity_d  = calc_parity(MAX_DATA_BW'(bus.data_i), PARITY_ODD != 0);
            bit_cnt_d = '0;
            tx_d      = 1'b0;
          end
        end
        ST_START: begin
          if (tick) begin
            state_d = ST_DATA;
            tx_d    = shift_q[0];
          end
        end
        ST_DATA: begin
          if (tick) begin
            shift_d = shift_q >> 1;
            if (bit_cnt_q == LAST_DATA) begin
              bit_cnt_d = '0;
              if (PARITY_EN != 0) begin
                state_d = ST_PARITY;
                tx_d    = parity_q;
              end else begin
                state_d = ST_STOP;
                tx_d    = 1'b1;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + BCW'(1);
              tx_d      = shift_q[1];
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (bit_cnt_q == LAST_STOP) begin
              state_d   = ST_IDLE;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + BCW'(1);
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          tx_d    = 1'b1;
        end
      endcase
    end
  end

  // State, datapath and line register; the line idles high out of reset.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      parity_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      parity_q  <= parity_d;
    end
  end

  assign tx_o        = tx_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign bus.ready_o = (state_q == ST_IDLE);

endmodule
